// File: rtl/mem_io_responder_if.sv
// mem_io_responder_if -- CPU byte-wide memory bus between the CPU (master)
// and the memory/I-O responder (slave).
//   mem_a          : CPU byte address (bits 17:0 decoded by the responder)
//   mem_dout       : CPU write data
//   mem_wr         : 1 = write, 0 = read
//   mem_din        : read data, valid the cycle after the address
//   io_buffer_full : UART TX queue is near full, CPU should back off
interface mem_io_responder_if;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output mem_a,
        output mem_dout,
        output mem_wr,
        input  mem_din,
        input  io_buffer_full
    );

    modport slave (
        input  mem_a,
        input  mem_dout,
        input  mem_wr,
        output mem_din,
        output io_buffer_full
    );
endinterface

// File: rtl/mem_io_responder.sv
// mem_io_responder -- responder end of the CPU byte-wide memory bus.
// Serves a 128 KB RAM with one-cycle read latency and decodes I/O space
// (mem_a[17:16] == 2'b11): UART TX queue (0x30000 write), optional UART RX
// queue (0x30000 read), free-running cycle counter with a coherent 32-bit
// snapshot (0x30004..0x30007 read) and program-stop (0x30004 write).
//
// Ports:
//   clk_in, rst_in   : clock, synchronous active-high reset
//   bus (slave)      : mem_a, mem_dout, mem_wr in; mem_din, io_buffer_full out
//   uart_tx_data/valid/ready : TX queue head and handshake to the UART sink
//   uart_rx_data/valid       : received bytes (used only with MEM_IO_RX_EN)
//   program_stop     : sticky, program has ended and TX has drained
//   tx_overflow      : sticky, a TX push was dropped on a full queue
//
// Build option: define MEM_IO_RX_EN to instantiate the RX FIFO. Without it
// the RX inputs are ignored and reads of 0x30000 return 0x00.
module mem_io_responder #(
    parameter int RAM_ADDR_W    = 17,
    parameter int TX_DEPTH_LOG2 = 4,
    parameter int RX_DEPTH_LOG2 = 4,
    parameter int FULL_MARGIN   = 2
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    mem_io_responder_if.slave        bus,
    output logic [7:0]               uart_tx_data,
    output logic                     uart_tx_valid,
    input  logic                     uart_tx_ready,
    input  logic [7:0]               uart_rx_data,
    input  logic                     uart_rx_valid,
    output logic                     program_stop,
    output logic                     tx_overflow
);

    localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
    localparam int TX_CNT_W = TX_DEPTH_LOG2 + 1;
    localparam logic [TX_CNT_W-1:0]      TX_CNT_ZERO = TX_CNT_W'(0);
    localparam logic [TX_CNT_W-1:0]      TX_CNT_ONE  = TX_CNT_W'(1);
    localparam logic [TX_CNT_W-1:0]      TX_FULL_CNT = TX_CNT_W'(TX_DEPTH);
    // Free slots <= FULL_MARGIN is the same as count >= depth - margin.
    localparam logic [TX_CNT_W-1:0]      TX_NEAR_CNT = TX_CNT_W'(TX_DEPTH - FULL_MARGIN);
    localparam logic [TX_DEPTH_LOG2-1:0] TX_PTR_ONE  = TX_DEPTH_LOG2'(1);

    localparam logic [15:0] OFF_UART = 16'h0000;
    localparam logic [15:0] OFF_CNT0 = 16'h0004;
    localparam logic [15:0] OFF_CNT1 = 16'h0005;
    localparam logic [15:0] OFF_CNT2 = 16'h0006;
    localparam logic [15:0] OFF_CNT3 = 16'h0007;

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_DRAIN   = 2'b01,
        ST_STOPPED = 2'b10
    } stop_state_t;

    // Address decode
    logic                    io_s;
    logic [15:0]             io_off_s;
    logic [RAM_ADDR_W-1:0]   ram_addr_s;
    logic                    ram_we_s;
    logic                    rx_rd_req_s;

    // RAM storage (not reset)
    logic [7:0]              ram_r [0:(1 << RAM_ADDR_W)-1];

    // TX FIFO
    logic [7:0]              tx_mem_r [0:TX_DEPTH-1];
    logic [TX_DEPTH_LOG2-1:0] tx_wptr_r;
    logic [TX_DEPTH_LOG2-1:0] tx_rptr_r;
    logic [TX_CNT_W-1:0]     tx_count_r;
    logic [TX_CNT_W-1:0]     tx_count_next_s;
    logic                    tx_push_req_s;
    logic [7:0]              tx_push_data_s;
    logic                    tx_push_ok_s;
    logic                    tx_pop_s;
    logic                    tx_full_s;
    logic                    tx_overflow_r;
    logic                    io_buffer_full_r;

    // RX FIFO view used by the read mux
    logic                    rx_pop_s;
    logic [7:0]              rx_head_s;

    // Counter, snapshot, stop sequence, read data
    logic [31:0]             counter_r;
    logic [31:0]             snapshot_r;
    logic                    snap_load_s;
    logic                    stop_wr_s;
    logic                    stop_req_r;
    stop_state_t             state_r;
    stop_state_t             state_next_s;
    logic                    program_stop_r;
    logic [7:0]              mem_din_next_s;
    logic [7:0]              mem_din_r;

    assign io_s        = (bus.mem_a[17:16] == 2'b11);
    assign io_off_s    = bus.mem_a[15:0];
    assign ram_addr_s  = bus.mem_a[RAM_ADDR_W-1:0];
    assign ram_we_s    = bus.mem_wr && !io_s;
    assign rx_rd_req_s = !bus.mem_wr && io_s && (io_off_s == OFF_UART);

    assign tx_full_s    = (tx_count_r == TX_FULL_CNT);
    assign uart_tx_valid = (tx_count_r != TX_CNT_ZERO);
    assign uart_tx_data  = tx_mem_r[tx_rptr_r];
    assign tx_pop_s      = uart_tx_valid && uart_tx_ready;
    // A push into a full queue still fits when the head leaves in the same cycle.
    assign tx_push_ok_s  = tx_push_req_s && (!tx_full_s || tx_pop_s);

    assign bus.mem_din        = mem_din_r;
    assign bus.io_buffer_full = io_buffer_full_r;
    assign program_stop       = program_stop_r;
    assign tx_overflow        = tx_overflow_r;

    // RAM write port; contents survive reset
    always_ff @(posedge clk_in) begin
        if (ram_we_s) begin
            ram_r[ram_addr_s] <= bus.mem_dout;
        end
    end

    // I/O write decode: TX pushes and the stop request
    always_comb begin
        tx_push_req_s  = 1'b0;
        tx_push_data_s = 8'h00;
        stop_wr_s      = 1'b0;
        if (bus.mem_wr && io_s) begin
            if (io_off_s == OFF_UART) begin
                // A zero byte is a no-op so software can pad writes freely.
                tx_push_req_s  = (bus.mem_dout != 8'h00);
                tx_push_data_s = bus.mem_dout;
            end else if (io_off_s == OFF_CNT0) begin
                // Stop marker: a 0x00 byte tells the host the stream has ended.
                tx_push_req_s  = 1'b1;
                tx_push_data_s = 8'h00;
                stop_wr_s      = 1'b1;
            end else begin
                tx_push_req_s  = 1'b0;
            end
        end else begin
            tx_push_req_s = 1'b0;
        end
    end

    // TX occupancy next-state
    always_comb begin
        tx_count_next_s = tx_count_r;
        case ({tx_push_ok_s, tx_pop_s})
            2'b10:   tx_count_next_s = tx_count_r + TX_CNT_ONE;
            2'b01:   tx_count_next_s = tx_count_r - TX_CNT_ONE;
            default: tx_count_next_s = tx_count_r;
        endcase
    end

    // TX pointers, occupancy, near-full flag and sticky overflow
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_wptr_r        <= TX_DEPTH_LOG2'(0);
            tx_rptr_r        <= TX_DEPTH_LOG2'(0);
            tx_count_r       <= TX_CNT_ZERO;
            io_buffer_full_r <= 1'b0;
            tx_overflow_r    <= 1'b0;
        end else begin
            if (tx_push_ok_s) begin
                tx_wptr_r <= tx_wptr_r + TX_PTR_ONE;
            end
            if (tx_pop_s) begin
                tx_rptr_r <= tx_rptr_r + TX_PTR_ONE;
            end
            tx_count_r       <= tx_count_next_s;
            io_buffer_full_r <= (tx_count_next_s >= TX_NEAR_CNT);
            if (tx_push_req_s && !tx_push_ok_s) begin
                tx_overflow_r <= 1'b1;
            end
        end
    end

    // TX storage; stale entries are harmless because reset clears the pointers
    always_ff @(posedge clk_in) begin
        if (tx_push_ok_s) begin
            tx_mem_r[tx_wptr_r] <= tx_push_data_s;
        end
    end

`ifdef MEM_IO_RX_EN
    localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
    localparam int RX_CNT_W = RX_DEPTH_LOG2 + 1;
    localparam logic [RX_CNT_W-1:0]      RX_CNT_ZERO = RX_CNT_W'(0);
    localparam logic [RX_CNT_W-1:0]      RX_CNT_ONE  = RX_CNT_W'(1);
    localparam logic [RX_CNT_W-1:0]      RX_FULL_CNT = RX_CNT_W'(RX_DEPTH);
    localparam logic [RX_DEPTH_LOG2-1:0] RX_PTR_ONE  = RX_DEPTH_LOG2'(1);

    logic [7:0]               rx_mem_r [0:RX_DEPTH-1];
    logic [RX_DEPTH_LOG2-1:0] rx_wptr_r;
    logic [RX_DEPTH_LOG2-1:0] rx_rptr_r;
    logic [RX_CNT_W-1:0]      rx_count_r;
    logic                     rx_push_ok_s;

    // Popping an empty queue returns 0x00; a same-cycle push is still kept.
    assign rx_pop_s     = rx_rd_req_s && (rx_count_r != RX_CNT_ZERO);
    assign rx_push_ok_s = uart_rx_valid && ((rx_count_r != RX_FULL_CNT) || rx_pop_s);
    assign rx_head_s    = rx_mem_r[rx_rptr_r];

    // RX pointers and occupancy; a push into a full queue is dropped silently
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_wptr_r  <= RX_DEPTH_LOG2'(0);
            rx_rptr_r  <= RX_DEPTH_LOG2'(0);
            rx_count_r <= RX_CNT_ZERO;
        end else begin
            if (rx_push_ok_s) begin
                rx_wptr_r <= rx_wptr_r + RX_PTR_ONE;
            end
            if (rx_pop_s) begin
                rx_rptr_r <= rx_rptr_r + RX_PTR_ONE;
            end
            case ({rx_push_ok_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + RX_CNT_ONE;
                2'b01:   rx_count_r <= rx_count_r - RX_CNT_ONE;
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // RX storage
    always_ff @(posedge clk_in) begin
        if (rx_push_ok_s) begin
            rx_mem_r[rx_wptr_r] <= uart_rx_data;
        end
    end
`else
    assign rx_pop_s  = 1'b0;
    assign rx_head_s = 8'h00;
`endif

    // Inputs that some build configurations do not consume
    logic unused_s;
    assign unused_s = ^{bus.mem_a[31:18], uart_rx_data, uart_rx_valid,
                        rx_rd_req_s, (RX_DEPTH_LOG2 > 0)};

    // Read data mux; the result is registered so it appears the next cycle
    always_comb begin
        mem_din_next_s = 8'h00;
        snap_load_s    = 1'b0;
        if (!bus.mem_wr) begin
            if (!io_s) begin
                mem_din_next_s = ram_r[ram_addr_s];
            end else begin
                case (io_off_s)
                    OFF_UART: mem_din_next_s = rx_pop_s ? rx_head_s : 8'h00;
                    OFF_CNT0: begin
                        // Low byte read freezes the whole dword for the upper bytes.
                        mem_din_next_s = counter_r[7:0];
                        snap_load_s    = 1'b1;
                    end
                    OFF_CNT1: mem_din_next_s = snapshot_r[15:8];
                    OFF_CNT2: mem_din_next_s = snapshot_r[23:16];
                    OFF_CNT3: mem_din_next_s = snapshot_r[31:24];
                    default:  mem_din_next_s = 8'h00;
                endcase
            end
        end else begin
            mem_din_next_s = 8'h00;
        end
    end

    // Read data register, cycle counter, snapshot and stop request
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mem_din_r  <= 8'h00;
            counter_r  <= 32'h0000_0000;
            snapshot_r <= 32'h0000_0000;
            stop_req_r <= 1'b0;
        end else begin
            mem_din_r <= mem_din_next_s;
            if (!program_stop_r) begin
                counter_r <= counter_r + 32'd1;
            end
            if (snap_load_s) begin
                snapshot_r <= counter_r;
            end
            if (stop_wr_s) begin
                stop_req_r <= 1'b1;
            end
        end
    end

    // Stop sequence state register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r        <= ST_RUN;
            program_stop_r <= 1'b0;
        end else begin
            state_r        <= state_next_s;
            program_stop_r <= (state_next_s == ST_STOPPED);
        end
    end

    // Stop sequence next state: wait for the TX queue to drain completely
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (stop_req_r) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if ((tx_count_r == TX_CNT_ZERO) && !tx_pop_s) begin
                    state_next_s = ST_STOPPED;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_STOPPED: state_next_s = ST_STOPPED;
            default:    state_next_s = ST_RUN;
        endcase
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: a directed vector table, a few
// hand-written multi-cycle sequences and a randomized run, all scored against
// a queue-based reference model of the bus/I-O behaviour.
module tb_mem_io_responder;

`ifdef MEM_IO_RX_EN
    localparam bit RX_ON = 1'b1;
`else
    localparam bit RX_ON = 1'b0;
`endif

    logic       clk_in = 1'b0;
    logic       rst_in;
    logic [7:0] uart_tx_data;
    logic       uart_tx_valid;
    logic       uart_tx_ready;
    logic [7:0] uart_rx_data;
    logic       uart_rx_valid;
    logic       program_stop;
    logic       tx_overflow;

    mem_io_responder_if bus();

    mem_io_responder dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .bus           (bus),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .program_stop  (program_stop),
        .tx_overflow   (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Reference model state
    logic [7:0]  tx_q[$];
    logic [7:0]  rx_q[$];
    logic [7:0]  ram_m [int];
    logic [31:0] cnt_m;
    logic [31:0] snap_m;
    bit          stopreq_m, drain_m, stopped_m, ovf_m;
    logic [7:0]  exp_din;
    bit          din_known;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  d;
        logic        wr;
        logic        rdy;
        logic [3:0]  chk;     // [0] din, [1] tx valid/data, [2] full, [3] overflow
        logic [7:0]  e_din;
        logic        e_valid;
        logic [7:0]  e_txd;
        logic        e_full;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic [31:0] a;
        logic        io;
        logic [15:0] off;
        int          tx_pre, rx_pre;
        bit          tx_pop, rx_pop, push_req, stop_wr;
        logic [7:0]  pd;
        logic [7:0]  junk;
        a   = bus.mem_a;
        io  = (a[17:16] == 2'b11);
        off = a[15:0];
        din_known = 1'b0;
        if (rst_in) begin
            tx_q.delete();
            rx_q.delete();
            cnt_m = 32'h0; snap_m = 32'h0;
            stopreq_m = 1'b0; drain_m = 1'b0; stopped_m = 1'b0; ovf_m = 1'b0;
            exp_din = 8'h00; din_known = 1'b1;
        end else begin
            tx_pre = tx_q.size();
            rx_pre = rx_q.size();
            tx_pop = (tx_pre > 0) && uart_tx_ready;
            rx_pop = 1'b0; push_req = 1'b0; stop_wr = 1'b0; pd = 8'h00;
            if (!bus.mem_wr) begin
                din_known = 1'b1;
                exp_din   = 8'h00;
                if (!io) begin
                    if (ram_m.exists(int'(a[16:0]))) exp_din = ram_m[int'(a[16:0])];
                    else din_known = 1'b0;
                end else if (off == 16'h0000) begin
                    if (RX_ON && rx_pre > 0) begin
                        rx_pop  = 1'b1;
                        exp_din = rx_q.pop_front();
                    end
                end else if (off == 16'h0004) begin
                    exp_din = cnt_m[7:0];
                    snap_m  = cnt_m;
                end else if (off == 16'h0005) exp_din = snap_m[15:8];
                else if (off == 16'h0006) exp_din = snap_m[23:16];
                else if (off == 16'h0007) exp_din = snap_m[31:24];
            end else begin
                if (!io) ram_m[int'(a[16:0])] = bus.mem_dout;
                else if (off == 16'h0000 && bus.mem_dout != 8'h00) begin
                    push_req = 1'b1; pd = bus.mem_dout;
                end else if (off == 16'h0004) begin
                    push_req = 1'b1; pd = 8'h00; stop_wr = 1'b1;
                end
            end
            if (RX_ON && uart_rx_valid && (rx_pre < 16 || rx_pop)) rx_q.push_back(uart_rx_data);
            if (!stopped_m) cnt_m = cnt_m + 32'd1;
            if (drain_m && tx_pre == 0) stopped_m = 1'b1;
            if (stopreq_m) drain_m = 1'b1;
            if (stop_wr) stopreq_m = 1'b1;
            if (tx_pop) junk = tx_q.pop_front();
            if (push_req) begin
                if (tx_pre < 16 || tx_pop) tx_q.push_back(pd);
                else ovf_m = 1'b1;
            end
        end
    endtask

    task automatic check_outputs();
        if (din_known) chk("mem_din", bus.mem_din, exp_din);
        chk("tx_valid", uart_tx_valid, tx_q.size() != 0);
        if (tx_q.size() != 0) chk("tx_data", uart_tx_data, tx_q[0]);
        chk("io_buffer_full", bus.io_buffer_full, (16 - tx_q.size()) <= 2);
        chk("tx_overflow", tx_overflow, ovf_m);
        chk("program_stop", program_stop, stopped_m);
    endtask

    task automatic step(input logic [31:0] a, input logic [7:0] d, input logic wr,
                        input logic rdy, input logic [7:0] rxd, input logic rxv);
        bus.mem_a     = a;
        bus.mem_dout  = d;
        bus.mem_wr    = wr;
        uart_tx_ready = rdy;
        uart_rx_data  = rxd;
        uart_rx_valid = rxv;
        model_edge();
        @(posedge clk_in);
        #1;
        check_outputs();
    endtask

    task automatic idle(input logic rdy);
        step(32'h0003_000C, 8'h00, 1'b0, rdy, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst_in = 1'b1;
        idle(1'b0);
        idle(1'b0);
        rst_in = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] emitted[$];
        logic [7:0] exp_emit [4];
        logic [7:0] exp_rx [3];
        logic [7:0] v1, v2;
        int         empty_at, stop_at, n;
        logic [31:0] a;
        logic [7:0]  d;

        vecs[0]  = '{32'h0000_0124, 8'h3C, 1'b1, 1'b0, 4'b0010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1]  = '{32'h0000_0123, 8'hA5, 1'b1, 1'b0, 4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2]  = '{32'h0000_0123, 8'h00, 1'b0, 1'b0, 4'b0001, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3]  = '{32'h0000_0124, 8'h00, 1'b0, 1'b0, 4'b0001, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{32'h0003_0000, 8'h48, 1'b1, 1'b0, 4'b0010, 8'h00, 1'b1, 8'h48, 1'b0, 1'b0};
        vecs[5]  = '{32'h0003_0000, 8'h00, 1'b1, 1'b0, 4'b0010, 8'h00, 1'b1, 8'h48, 1'b0, 1'b0};
        vecs[6]  = '{32'h0003_0000, 8'h69, 1'b1, 1'b0, 4'b1110, 8'h00, 1'b1, 8'h48, 1'b0, 1'b0};
        vecs[7]  = '{32'h0003_0000, 8'h00, 1'b0, 1'b0, 4'b0001, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[8]  = '{32'hFFFC_0123, 8'h5A, 1'b1, 1'b0, 4'b0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[9]  = '{32'h0000_0123, 8'h00, 1'b0, 1'b0, 4'b0001, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[10] = '{32'h0002_0123, 8'h00, 1'b0, 1'b0, 4'b0001, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[11] = '{32'h0003_0008, 8'h77, 1'b1, 1'b0, 4'b1010, 8'h00, 1'b1, 8'h48, 1'b0, 1'b0};
        vecs[12] = '{32'h0003_0009, 8'h00, 1'b0, 1'b0, 4'b0001, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

        bus.mem_a = 32'h0; bus.mem_dout = 8'h00; bus.mem_wr = 1'b0;
        uart_tx_ready = 1'b0; uart_rx_data = 8'h00; uart_rx_valid = 1'b0;

        // Directed table: RAM latency, address aliasing, TX pushes incl. zero byte
        do_reset();
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].a, vecs[i].d, vecs[i].wr, vecs[i].rdy, 8'h00, 1'b0);
            if (vecs[i].chk[0]) chk($sformatf("vec%0d_din", i), bus.mem_din, vecs[i].e_din);
            if (vecs[i].chk[1]) begin
                chk($sformatf("vec%0d_valid", i), uart_tx_valid, vecs[i].e_valid);
                if (vecs[i].e_valid) chk($sformatf("vec%0d_txd", i), uart_tx_data, vecs[i].e_txd);
            end
            if (vecs[i].chk[2]) chk($sformatf("vec%0d_full", i), bus.io_buffer_full, vecs[i].e_full);
            if (vecs[i].chk[3]) chk($sformatf("vec%0d_ovf", i), tx_overflow, vecs[i].e_ovf);
        end

        // TX fill: near-full after 14th byte, 17th dropped with overflow
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            step(32'h0003_0000, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
            if (i == 13) chk("full_after_13", bus.io_buffer_full, 1'b0);
            if (i == 14) chk("full_after_14", bus.io_buffer_full, 1'b1);
        end
        step(32'h0003_0000, 8'hEE, 1'b1, 1'b0, 8'h00, 1'b0);
        chk("ovf_on_17th", tx_overflow, 1'b1);
        chk("head_after_drop", uart_tx_data, 8'h01);

        // Same fill, 17th write coincides with a pop: no overflow
        do_reset();
        for (int i = 1; i <= 16; i++) step(32'h0003_0000, 8'(i), 1'b1, 1'b0, 8'h00, 1'b0);
        step(32'h0003_0000, 8'hEE, 1'b1, 1'b1, 8'h00, 1'b0);
        chk("no_ovf_push_pop", tx_overflow, 1'b0);
        chk("full_push_pop", bus.io_buffer_full, 1'b1);
        chk("head_push_pop", uart_tx_data, 8'h02);

        // Counter snapshot coherence at 0x000001FF
        do_reset();
        n = 0;
        while (cnt_m != 32'h0000_01FF && n < 1000) begin
            idle(1'b0);
            n++;
        end
        chk("counter_reach", cnt_m, 32'h0000_01FF);
        step(32'h0003_0004, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("cnt_byte0", bus.mem_din, 8'hFF);
        step(32'h0003_0005, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("cnt_byte1", bus.mem_din, 8'h01);
        step(32'h0003_0006, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("cnt_byte2", bus.mem_din, 8'h00);
        step(32'h0003_0007, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("cnt_byte3", bus.mem_din, 8'h00);

        // Stop sequence: marker emitted last, stop one cycle after drain, counter frozen
        do_reset();
        step(32'h0003_0000, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0);
        step(32'h0003_0000, 8'h22, 1'b1, 1'b0, 8'h00, 1'b0);
        step(32'h0003_0000, 8'h33, 1'b1, 1'b0, 8'h00, 1'b0);
        if (uart_tx_valid) emitted.push_back(uart_tx_data);
        step(32'h0003_0004, 8'h99, 1'b1, 1'b1, 8'h00, 1'b0);
        empty_at = -1;
        stop_at  = -1;
        for (int i = 0; i < 30; i++) begin
            if (uart_tx_valid) emitted.push_back(uart_tx_data);
            idle(1'b1);
            if (empty_at < 0 && !uart_tx_valid) empty_at = i;
            if (stop_at < 0 && program_stop) stop_at = i;
        end
        exp_emit = '{8'h11, 8'h22, 8'h33, 8'h00};
        chk("emit_count", emitted.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("emit_byte%0d", k),
                (k < emitted.size()) ? {24'h0, emitted[k]} : 32'hDEAD_BEEF, exp_emit[k]);
        chk("stop_seen", stop_at >= 0, 1'b1);
        chk("stop_timing", stop_at, empty_at + 1);
        step(32'h0003_0004, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        v1 = bus.mem_din;
        idle(1'b1);
        idle(1'b1);
        step(32'h0003_0004, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
        v2 = bus.mem_din;
        chk("counter_frozen", v2, v1);

        // RX path: two pushes then three pops; pop+push on empty
        do_reset();
        if (RX_ON) exp_rx = '{8'h31, 8'h32, 8'h00};
        else       exp_rx = '{8'h00, 8'h00, 8'h00};
        step(32'h0003_000C, 8'h00, 1'b0, 1'b0, 8'h31, 1'b1);
        step(32'h0003_000C, 8'h00, 1'b0, 1'b0, 8'h32, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
            chk($sformatf("rx_pop%0d", k), bus.mem_din, exp_rx[k]);
        end
        step(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h55, 1'b1);
        chk("rx_pop_push_empty", bus.mem_din, 8'h00);
        step(32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        chk("rx_retained", bus.mem_din, RX_ON ? 8'h55 : 8'h00);

        // Randomized traffic scored by the model every cycle
        do_reset();
        for (int i = 0; i < 800; i++) begin
            d = 8'($urandom());
            case ($urandom_range(0, 9))
                0, 1: step((32'($urandom()) & 32'hFFFC_0000) | (32'($urandom_range(0, 2)) << 16)
                           | (32'h100 + 32'($urandom_range(0, 15))), d, 1'b1,
                           ($urandom_range(0, 3) == 0), 8'($urandom()), ($urandom_range(0, 2) == 0));
                2, 3: step((32'($urandom()) & 32'hFFFC_0000) | (32'($urandom_range(0, 2)) << 16)
                           | (32'h100 + 32'($urandom_range(0, 15))), d, 1'b0,
                           ($urandom_range(0, 3) == 0), 8'($urandom()), ($urandom_range(0, 2) == 0));
                4, 5: step(32'h0003_0000 | (32'($urandom()) & 32'hFFFC_0000),
                           ($urandom_range(0, 3) == 0) ? 8'h00 : d, 1'b1,
                           ($urandom_range(0, 3) == 0), 8'($urandom()), ($urandom_range(0, 2) == 0));
                6:    step(32'h0003_0004 + 32'($urandom_range(0, 3)), d, 1'b0,
                           ($urandom_range(0, 3) == 0), 8'($urandom()), ($urandom_range(0, 2) == 0));
                7:    step(32'h0003_0000, d, 1'b0,
                           ($urandom_range(0, 3) == 0), 8'($urandom()), ($urandom_range(0, 2) == 0));
                8: begin
                    a = 32'h0003_0000 | 32'($urandom_range(8, 16'hFFFF));
                    step(a, d, 1'($urandom()), ($urandom_range(0, 3) == 0),
                         8'($urandom()), ($urandom_range(0, 2) == 0));
                end
                default: idle(1'($urandom()));
            endcase
        end
        step(32'h0003_0004, 8'h01, 1'b1, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 40; i++) idle(1'b1);
        chk("random_final_stop", program_stop, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_io_responder.md
Name: mem_io_responder

Overview:
- Responder end of the CPU byte-wide memory bus (address, data-out, write strobe, data-in, io_buffer_full).
- Serves the 128 KB RAM with one-cycle read latency.
- Decodes I/O space (addr[17:16]==2'b11): UART TX queue, optional UART RX queue, cycle counter, program-stop.
- Sits beside the CPU top; drives the CPU's data-in and io_buffer_full inputs.

Parameters:
RAM_ADDR_W, 17, RAM byte-address width (2^17 = 128 KB)
TX_DEPTH_LOG2, 4, TX FIFO depth = 16 bytes
RX_DEPTH_LOG2, 4, RX FIFO depth = 16 bytes
FULL_MARGIN, 2, io_buffer_full asserts when free TX slots <= FULL_MARGIN

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
mem_a  in  32  CPU address; bits 17:0 decoded
mem_dout  in  8  CPU write data
mem_wr  in  1  1 = write, 0 = read
mem_din  out  8  read data, valid the cycle after address
io_buffer_full  out  1  TX FIFO near full
uart_tx_data  out  8  TX FIFO head byte
uart_tx_valid  out  1  TX FIFO non-empty
uart_tx_ready  in  1  sink accepts the head byte
uart_rx_data  in  8  received byte (RX feature only)
uart_rx_valid  in  1  push uart_rx_data (RX feature only)
program_stop  out  1  sticky; program has ended and TX has drained
tx_overflow  out  1  sticky; a TX push was dropped

Behaviour:
- Reset values:
  - mem_din=0, io_buffer_full=0, uart_tx_valid=0, program_stop=0, tx_overflow=0.
  - FIFOs empty, cycle counter=0, counter snapshot=0, stop_req=0.
  - RAM contents are not reset.
- Decode:
  - io = (mem_a[17:16]==2'b11).
  - Otherwise RAM at mem_a[RAM_ADDR_W-1:0]; higher address bits are ignored.
- RAM:
  - Write: when mem_wr=1, the byte is stored at the clock edge.
  - Read: when mem_wr=0, mem_din equals ram[addr] on the next cycle.
  - A read every cycle is legal, giving one byte per cycle.
- I/O read (result registered into mem_din the next cycle):
  - 0x30000: pop RX FIFO head. If empty, or feature off, return 0x00 with no pop.
  - 0x30004: return counter[7:0] and latch the full 32-bit counter into the snapshot in the same cycle.
  - 0x30005..0x30007: return snapshot[15:8], [23:16], [31:24]. This keeps the dword coherent.
  - Any other I/O address returns 0x00.
- I/O write:
  - 0x30000: data 0x00 is ignored. Otherwise push to the TX FIFO. If the FIFO is full and there is no same-cycle pop, drop the byte and set tx_overflow.
  - 0x30004: push 0x00 to the TX FIFO (same full rules) and set stop_req.
  - Any other I/O address is ignored.
- Cycle counter:
  - 32-bit; increments every cycle after reset; wraps 0xFFFFFFFF -> 0.
  - Freezes once program_stop=1.
- TX FIFO:
  - uart_tx_valid = !empty; uart_tx_data = head.
  - Pop on uart_tx_valid && uart_tx_ready.
  - Simultaneous push and pop when full: both occur, count unchanged, no overflow.
  - Pointers wrap modulo depth.
- io_buffer_full is registered: 1 when (TX_DEPTH - count_next) <= FULL_MARGIN.
- RX FIFO:
  - Push on uart_rx_valid.
  - Push while full with no same-cycle pop: the byte is dropped silently.
  - Simultaneous pop and push on empty: the pop returns 0x00, and the pushed byte is retained.
- Stop sequence:
  - States: RUN -> DRAIN (stop_req set) -> STOPPED (TX FIFO empty and no TX handshake this cycle).
  - program_stop=1 in STOPPED, held until reset.
  - Bus traffic in DRAIN and STOPPED is still served.
- Reset mid-operation: FIFO contents are discarded and any in-flight read result is replaced by 0.

Optional Feature:
- MEM_IO_RX_EN defined: RX FIFO is instantiated and 0x30000 reads pop it.
- MEM_IO_RX_EN undefined:
  - No RX storage; uart_rx_data and uart_rx_valid are ignored.
  - 0x30000 reads return 0x00.
  - All other behaviour is identical.

Test Plan:
- Write 0xA5 @0x00123, then read 0x00123 next cycle -> mem_din=0xA5 one cycle after the read address. A back-to-back read of 0x00124 (preloaded 0x3C) -> 0x3C on the following cycle.
- Write 0x48, 0x00, 0x69 @0x30000 with uart_tx_ready=0 -> TX FIFO holds 2 bytes; uart_tx_data=0x48; uart_tx_valid=1.
- Write 16 bytes @0x30000 with ready=0 -> io_buffer_full rises after the 14th write; the 17th write is dropped and sets tx_overflow=1. The same case with ready=1 on the 17th write -> no overflow.
- Read 0x30004..0x30007 on consecutive cycles when the counter is 0x000001FF at the first read -> bytes 0xFF, 0x01, 0x00, 0x00. Counter increments between the reads do not alter the upper bytes.
- Write any value @0x30004 with 3 bytes queued, ready=1 -> 0x00 is emitted last; program_stop=1 one cycle after the FIFO empties; the counter then freezes.
- With MEM_IO_RX_EN: push 0x31, 0x32 via uart_rx_valid, then read 0x30000 three times -> 0x31, 0x32, 0x00. Without MEM_IO_RX_EN -> 0x00, 0x00, 0x00.
